frame_sync_ctrl: RTL and testbench

//   Synchronisation supervisor for the byte-stream frame aligner.
//   - Takes the aligner's header-hit pulses and runs the HUNT/VERIFY/LOCKED flywheel.
//   - Owns the in-frame byte position and qualifies payload bytes.
//   - Pulses a clear to the aligner to force a re-search when sync is lost.

---
 rtl/frame_sync_ctrl.sv | 170 +++++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation supervisor: runs the HUNT/VERIFY/LOCKED flywheel on
// aligner header hits, tracks the in-frame byte position and qualifies payload.
module frame_sync_ctrl #(
    parameter int FRAME_LEN = 12,
    parameter int HDR_LEN   = 2,
    parameter int LOCK_CNT  = 3,
    parameter int LOSS_CNT  = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         byte_vld,
    input  logic                         hdr_hit,
    output logic                         aligner_clr,
    output logic                         locked,
    output logic [$clog2(FRAME_LEN)-1:0] fr_byte_position,
    output logic                         payload_vld,
    output logic [1:0]                   sync_state,
    output logic [CNT_W-1:0]             lock_events,
    output logic [CNT_W-1:0]             loss_events
);

    localparam int POS_W  = $clog2(FRAME_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0]  PAY_LEN  = POS_W'(FRAME_LEN - HDR_LEN);
    localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] LOSS_V   = MISS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]   lock_ev_q, lock_ev_d;
    logic [CNT_W-1:0]   loss_ev_q, loss_ev_d;
    logic               clr_q, clr_d;
    logic               locked_q;
    logic               window_s, good_s, miss_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    assign window_s = byte_vld && (pos_q == POS_LAST);
    assign good_s   = window_s && hdr_hit;
    assign miss_s   = window_s && !hdr_hit;

    // Flywheel next-state, position and event-counter logic
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        lock_ev_d  = lock_ev_q;
        loss_ev_d  = loss_ev_q;
        clr_d      = 1'b0;
        if (!byte_vld) begin
            pos_d = pos_q;
        end else if (pos_q == POS_LAST) begin
            pos_d = '0;
        end else begin
            pos_d = pos_q + POS_W'(1);
        end

        case (state_q)
            ST_HUNT: begin
                pos_d = '0;
                if (byte_vld && hdr_hit) begin
                    if (LOCK_CNT == 1) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        miss_cnt_d = '0;
                        lock_ev_d  = sat_inc(lock_ev_q);
                    end else begin
                        state_d    = ST_VERIFY;
                        good_cnt_d = GOOD_W'(1);
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            ST_VERIFY: begin
                if (good_s) begin
                    if (good_cnt_q + GOOD_W'(1) == LOCK_V) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        miss_cnt_d = '0;
                        lock_ev_d  = sat_inc(lock_ev_q);
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end else if (miss_s) begin
                    state_d    = ST_HUNT;
                    pos_d      = '0;
                    good_cnt_d = '0;
                    clr_d      = 1'b1;
                end else begin
                    good_cnt_d = good_cnt_q;
                end
            end
            ST_LOCKED: begin
                // A good header always clears the miss run, even one short of loss
                if (good_s) begin
                    miss_cnt_d = '0;
                end else if (miss_s) begin
                    if (miss_cnt_q + MISS_W'(1) == LOSS_V) begin
                        state_d    = ST_HUNT;
                        pos_d      = '0;
                        miss_cnt_d = '0;
                        loss_ev_d  = sat_inc(loss_ev_q);
                        clr_d      = 1'b1;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MISS_W'(1);
                    end
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end
            default: begin
                state_d    = ST_HUNT;
                pos_d      = '0;
                good_cnt_d = '0;
                miss_cnt_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            pos_q      <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            lock_ev_q  <= '0;
            loss_ev_q  <= '0;
            clr_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            lock_ev_q  <= lock_ev_d;
            loss_ev_q  <= loss_ev_d;
            clr_q      <= clr_d;
            locked_q   <= (state_d == ST_LOCKED);
        end
    end

    assign aligner_clr      = clr_q;
    assign locked           = locked_q;
    assign sync_state       = state_q;
    assign fr_byte_position = pos_q;
    assign lock_events      = lock_ev_q;
    assign loss_events      = loss_ev_q;
    assign payload_vld      = byte_vld && (state_q == ST_LOCKED) && (pos_q < PAY_LEN);

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Randomised bench for frame_sync_ctrl against an integer flywheel model;
// a second instance with 2-bit counters exercises event-counter saturation.
module tb_frame_sync_ctrl;

    localparam int FL   = 12;
    localparam int HL   = 2;
    localparam int LCK  = 3;
    localparam int LSS  = 4;

    logic        clk;
    logic        reset;
    logic        byte_vld;
    logic        hdr_hit;
    logic        aligner_clr, locked, payload_vld;
    logic [3:0]  fr_byte_position;
    logic [1:0]  sync_state;
    logic [15:0] lock_events, loss_events;
    logic        aligner_clr2, locked2, payload_vld2;
    logic [3:0]  fr_byte_position2;
    logic [1:0]  sync_state2;
    logic [1:0]  lock_events2, loss_events2;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 HUNT, 1 VERIFY, 2 LOCKED
    int m_state, m_pos, m_good, m_miss, m_lock_tot, m_loss_tot;
    int m_clr;

    frame_sync_ctrl #(.FRAME_LEN(FL), .HDR_LEN(HL), .LOCK_CNT(LCK), .LOSS_CNT(LSS), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .byte_vld(byte_vld), .hdr_hit(hdr_hit),
        .aligner_clr(aligner_clr), .locked(locked), .fr_byte_position(fr_byte_position),
        .payload_vld(payload_vld), .sync_state(sync_state),
        .lock_events(lock_events), .loss_events(loss_events)
    );

    frame_sync_ctrl #(.FRAME_LEN(FL), .HDR_LEN(HL), .LOCK_CNT(LCK), .LOSS_CNT(LSS), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .byte_vld(byte_vld), .hdr_hit(hdr_hit),
        .aligner_clr(aligner_clr2), .locked(locked2), .fr_byte_position(fr_byte_position2),
        .payload_vld(payload_vld2), .sync_state(sync_state2),
        .lock_events(lock_events2), .loss_events(loss_events2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_lock_tot = 0; m_loss_tot = 0; m_clr = 0;
    endtask

    // one accepted clock edge with inputs v/h
    task automatic model_step(input bit v, input bit h);
        bit win;
        m_clr = 0;
        if (v) begin
            win = (m_pos == FL - 1);
            if (m_state == 0) begin
                if (h) begin
                    m_pos = 0;
                    m_good = 1;
                    m_state = 1;
                    if (m_good == LCK) begin
                        m_state = 2; m_miss = 0; m_lock_tot++;
                    end
                end
            end else begin
                m_pos = (m_pos + 1) % FL;
                if (win && m_state == 1) begin
                    if (h) begin
                        m_good++;
                        if (m_good == LCK) begin
                            m_state = 2; m_miss = 0; m_lock_tot++;
                        end
                    end else begin
                        m_state = 0; m_pos = 0; m_good = 0; m_clr = 1;
                    end
                end else if (win && m_state == 2) begin
                    if (h) begin
                        m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == LSS) begin
                            m_state = 0; m_pos = 0; m_miss = 0; m_loss_tot++; m_clr = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(input bit v);
        check_val("locked",   32'(locked),           32'(m_state == 2));
        check_val("state",    32'(sync_state),       32'(m_state));
        check_val("pos",      32'(fr_byte_position), 32'(m_pos));
        check_val("clr",      32'(aligner_clr),      32'(m_clr));
        check_val("payload",  32'(payload_vld),      32'(v && m_state == 2 && m_pos < FL - HL));
        check_val("lock_ev",  32'(lock_events),      32'(sat(m_lock_tot, 65535)));
        check_val("loss_ev",  32'(loss_events),      32'(sat(m_loss_tot, 65535)));
        check_val("lock_sat", 32'(lock_events2),     32'(sat(m_lock_tot, 3)));
        check_val("loss_sat", 32'(loss_events2),     32'(sat(m_loss_tot, 3)));
    endtask

    initial begin
        int sp;
        int p_hit, p_stray;
        bit v, h;
        reset = 1'b1;
        byte_vld = 1'b0;
        hdr_hit = 1'b0;
        model_reset();
        #12;
        check_all(1'b0);
        reset = 1'b0;
        sp = 0;
        for (int seg = 0; seg < 40; seg++) begin
            case (seg % 4)
                0, 2:    begin p_hit = 100; p_stray = 2; end
                1:       begin p_hit = 0;   p_stray = 0; end
                default: begin p_hit = 70;  p_stray = 5; end
            endcase
            sp = $urandom_range(FL - 1);
            for (int cyc = 0; cyc < 200; cyc++) begin
                @(negedge clk);
                v = ($urandom_range(99) < 75);
                if (v) begin
                    if (sp == FL - 1) h = ($urandom_range(99) < p_hit);
                    else              h = ($urandom_range(99) < p_stray);
                    sp = (sp + 1) % FL;
                end else begin
                    h = ($urandom_range(99) < 30);
                end
                byte_vld = v;
                hdr_hit  = h;
                #1;
                check_all(v);
                model_step(v, h);
                // asynchronous reset between edges, mid-stream
                if (seg == 6 && cyc == 150) begin
                    @(posedge clk);
                    #2;
                    reset = 1'b1;
                    #1;
                    model_reset();
                    check_all(1'b0);
                    check_val("rst_payload", 32'(payload_vld), 32'(0));
                    #1;
                    reset = 1'b0;
                end
            end
        end
        @(negedge clk);
        byte_vld = 1'b0;
        hdr_hit  = 1'b0;
        #1;
        check_all(1'b0);
        check_val("enough_locks", 32'(m_lock_tot >= 5), 32'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
